// File: rtl/ws2812_frame_feeder.sv
// ws2812_frame_feeder
// Avalon-MM slave that holds one frame of LED colours in a pixel RAM and
// feeds it, word by word, to a downstream WS2812b serial driver.
//
// Ports:
//   clk, reset          system clock; asynchronous active-low reset
//   avs_address         word address, MSB=1 pixel RAM, MSB=0 registers
//   avs_write/_writedata host write strobe and data
//   avs_read/_readdata  host read strobe and data (read latency 1)
//   irq                 DONE & IRQ_EN
//   drv_sync            start-frame pulse to the driver
//   drv_config          LED-count load pulse to the driver
//   drv_data            colour word, or LED count during drv_config
//   drv_idle            driver idle flag
//   drv_next_led        driver request for the next colour word
module ws2812_frame_feeder #(
  parameter int unsigned MAX_LEDS   = 256,
  parameter int unsigned PIX_AW     = 8,
  parameter int unsigned LED_DATA_W = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PIX_AW:0]       avs_address,
  input  logic                  avs_write,
  input  logic [31:0]           avs_writedata,
  input  logic                  avs_read,
  output logic [31:0]           avs_readdata,
  output logic                  irq,
  output logic                  drv_sync,
  output logic                  drv_config,
  output logic [LED_DATA_W-1:0] drv_data,
  input  logic                  drv_idle,
  input  logic                  drv_next_led
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEDS);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CFG  = 3'd1;
  localparam logic [2:0] S_PREF = 3'd2;
  localparam logic [2:0] S_SYNC = 3'd3;
  localparam logic [2:0] S_RUN  = 3'd4;

  logic [2:0]            state, state_nxt;
  logic [CNT_W-1:0]      led_count;
  logic                  irq_en, irq_en_nxt;
  logic                  done, done_nxt;
  logic [PIX_AW-1:0]     idx, idx_nxt;
  logic                  seen_busy, seen_busy_nxt;
  logic                  nl_q;
  logic                  load_pend, load_pend_nxt;
  logic [LED_DATA_W-1:0] pix_q;
  logic [LED_DATA_W-1:0] mem [MAX_LEDS];

  logic                  sync_nxt, config_nxt;
  logic                  ld_count, ld_pix;
  logic                  b_rd;
  logic [PIX_AW-1:0]     b_idx;

  logic                  ram_sel, reg_wr, ram_wr, ctrl_wr, cnt_wr, start;
  logic                  nl_rise, busy;
  logic [PIX_AW-1:0]     a_idx;

  // Upper write-data bits carry nothing for this block.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, avs_writedata[31:LED_DATA_W]};

  // Host access decode
  always_comb begin
    ram_sel = avs_address[PIX_AW];
    a_idx   = avs_address[PIX_AW-1:0];
    reg_wr  = avs_write & ~ram_sel;
    ram_wr  = avs_write & ram_sel;
    ctrl_wr = reg_wr && (a_idx == '0);
    cnt_wr  = reg_wr && (a_idx == PIX_AW'(1));
    start   = ctrl_wr & avs_writedata[0];
    nl_rise = drv_next_led & ~nl_q;
    busy    = (state != S_IDLE);
  end

  // Next-state and registered-output decode
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    seen_busy_nxt = seen_busy;
    load_pend_nxt = 1'b0;
    sync_nxt      = 1'b0;
    config_nxt    = 1'b0;
    ld_count      = 1'b0;
    ld_pix        = load_pend;
    b_rd          = 1'b0;
    b_idx         = idx;
    done_nxt      = done & ~(ctrl_wr & avs_writedata[2]);
    irq_en_nxt    = ctrl_wr ? avs_writedata[1] : irq_en;

    case (state)
      S_IDLE: begin
        if (start && (led_count != '0)) state_nxt = S_CFG;
      end
      S_CFG: begin
        if (drv_idle) begin
          config_nxt = 1'b1;
          ld_count   = 1'b1;
          idx_nxt    = '0;
          b_rd       = 1'b1;
          b_idx      = '0;
          state_nxt  = S_PREF;
        end
      end
      S_PREF: begin
        ld_pix    = 1'b1;
        state_nxt = S_SYNC;
      end
      S_SYNC: begin
        sync_nxt      = 1'b1;
        seen_busy_nxt = 1'b0;
        state_nxt     = S_RUN;
      end
      S_RUN: begin
        if (!drv_idle) seen_busy_nxt = 1'b1;
        // Advance only while words remain; the last index saturates.
        if (nl_rise && ((CNT_W'(idx) + CNT_W'(1)) < led_count)) begin
          idx_nxt       = idx + PIX_AW'(1);
          b_rd          = 1'b1;
          b_idx         = idx + PIX_AW'(1);
          load_pend_nxt = 1'b1;
        end
        if (seen_busy && drv_idle) begin
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Sequencer bookkeeping, control registers and driver outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx        <= '0;
      seen_busy  <= 1'b0;
      nl_q       <= 1'b0;
      load_pend  <= 1'b0;
      led_count  <= '0;
      irq_en     <= 1'b0;
      done       <= 1'b0;
      irq        <= 1'b0;
      drv_sync   <= 1'b0;
      drv_config <= 1'b0;
      drv_data   <= '0;
    end else begin
      idx        <= idx_nxt;
      seen_busy  <= seen_busy_nxt;
      nl_q       <= drv_next_led;
      load_pend  <= load_pend_nxt;
      irq_en     <= irq_en_nxt;
      done       <= done_nxt;
      irq        <= done_nxt & irq_en_nxt;
      drv_sync   <= sync_nxt;
      drv_config <= config_nxt;
      if (cnt_wr && !busy) begin
        led_count <= (avs_writedata[CNT_W-1:0] > MAX_CNT) ? MAX_CNT
                                                          : avs_writedata[CNT_W-1:0];
      end
      if (ld_count)    drv_data <= LED_DATA_W'(led_count);
      else if (ld_pix) drv_data <= pix_q;
    end
  end

  // Pixel RAM: host port A writes, feeder port B reads
  always_ff @(posedge clk) begin
    if (ram_wr) mem[a_idx] <= avs_writedata[LED_DATA_W-1:0];
    if (b_rd)   pix_q      <= mem[b_idx];
  end

  // Host read path, one cycle latency, holds between reads
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      if (ram_sel) begin
        avs_readdata <= 32'(mem[a_idx]);
      end else begin
        case (a_idx)
          PIX_AW'(0): avs_readdata <= {29'd0, done, irq_en, busy};
          PIX_AW'(1): avs_readdata <= 32'(led_count);
          default:    avs_readdata <= '0;
        endcase
      end
    end
  end

endmodule

// File: doc/ws2812_frame_feeder.md
Name: ws2812_frame_feeder

Overview:
- Avalon-MM slave that holds one frame of LED colours in an internal pixel RAM and sequences the downstream WS2812b serial driver.
- Sits directly upstream of that driver: it drives the driver's `sync`, `config_leds` and 24-bit `data` inputs, and follows its `idle` and `next_led` outputs.
- Software fills the pixel RAM, writes LED_COUNT, then sets START. The block configures the driver, streams every pixel word on demand, and raises DONE/irq when the driver returns to idle.

Parameters:
- MAX_LEDS, 256: pixel RAM depth; power of two.
- PIX_AW, 8: log2(MAX_LEDS), pixel index width.
- LED_DATA_W, 24: colour word width; must match the driver's data bus.

Ports:
- clk  in  1  system clock, same clock as the driver.
- reset  in  1  asynchronous, active-low reset.
- avs_address  in  PIX_AW+1  word address; MSB=1 selects pixel RAM, MSB=0 selects registers.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_read  in  1  read strobe.
- avs_readdata  out  32  read data, fixed read latency 1.
- irq  out  1  interrupt, equal to DONE & IRQ_EN.
- drv_sync  out  1  start-frame pulse to the driver.
- drv_config  out  1  LED-count load pulse to the driver.
- drv_data  out  LED_DATA_W  colour word, or the LED count during drv_config.
- drv_idle  in  1  driver idle flag.
- drv_next_led  in  1  driver request for the next colour word.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - All outputs are 0 in reset; FSM resets to IDLE.
  - Registers reset as: LED_COUNT=0, IRQ_EN=0, DONE=0, idx=0.
  - Pixel RAM contents are not reset.
  - Reset mid-frame aborts immediately; drv_sync and drv_config are 0 while reset is low.
- Register map (avs_address MSB=0):
  - addr 0 CTRL write: bit0 START (self-clearing), bit1 IRQ_EN, bit2 writes 1 to clear DONE.
  - addr 0 CTRL read: bit0 BUSY (FSM != IDLE), bit1 IRQ_EN, bit2 DONE.
  - addr 1 LED_COUNT: bits [15:0]. Writes above MAX_LEDS are clamped to MAX_LEDS. Writes while BUSY are ignored.
  - Other register addresses read 0 and ignore writes.
- Pixel RAM (avs_address MSB=1):
  - Index is avs_address[PIX_AW-1:0]; word is writedata[23:0] (GRB, sent MSB first); reads return 24 bits zero-extended.
  - Dual-ported: host port A, feeder read port B, so host access never stalls.
  - Host writes during BUSY are allowed; they affect only words not yet fetched.
- avs_readdata is registered and valid the cycle after avs_read; it holds its value otherwise.
- FSM states:
  - IDLE: START with LED_COUNT!=0 → CFG. START with LED_COUNT=0 is ignored. START while BUSY is ignored.
  - CFG: wait for drv_idle=1. In that cycle, drv_data = LED_COUNT zero-extended and drv_config=1 for exactly 1 cycle; set idx=0 and issue RAM read of index 0 → PREF.
  - PREF: 1 cycle; RAM data for index 0 is registered into drv_data → SYNC.
  - SYNC: drv_sync=1 for exactly 1 cycle, with drv_data=pixel[0] stable → RUN. Clear the seen_busy flag.
  - RUN: set seen_busy when drv_idle=0.
    - On each rising edge of drv_next_led, if idx < LED_COUNT-1: idx+1, issue RAM read; drv_data takes the new word 2 cycles after the rise.
    - At idx = LED_COUNT-1, the rise is ignored (saturate).
    - When seen_busy=1 and drv_idle=1 → IDLE, set DONE.
- drv_data stays constant outside the update cycles above.
- Edge detect uses a registered copy of drv_next_led; a level held high counts once.
- Simultaneous START and DONE-clear write in the same CTRL write: both take effect.
- DONE set and clear in the same cycle: set wins.

Test Plan:
- Write pixels 0..2 = 0xFF0000, 0x00FF00, 0x0000FF; LED_COUNT=3; START → one drv_config pulse with drv_data=3, then 1 PREF cycle, then one drv_sync with drv_data=0xFF0000. Driver model then sees 0x00FF00 and 0x0000FF on successive loads; DONE=1 after driver idle.
- IRQ_EN=1 with a 1-LED frame → irq rises with DONE. Write CTRL bit2=1 → irq=0, DONE=0.
- LED_COUNT=0, then START → BUSY stays 0; no drv_config or drv_sync.
- Write LED_COUNT=1000 → readback 256. START while BUSY → ignored. LED_COUNT write while BUSY → readback unchanged.
- Hold drv_next_led high for 40 cycles with LED_COUNT=2 → idx advances once. Extra next_led rise at the last LED → drv_data unchanged.
- Assert reset in RUN → all outputs 0 and BUSY=0 immediately. After release, a new START completes normally.
